// File: rtl/proc_fetch_pkg.sv
// Shared TinyRV1 fetch-stage definitions: reset PC, FSM state encodings,
// the slot record kept for every in-flight or buffered fetch, and a PC helper.
package proc_fetch_pkg;

  localparam logic [31:0] RESET_ADDR = 32'h0000_0200;

  typedef logic [1:0] fetch_state_t;

  localparam fetch_state_t BOOT  = 2'd0;
  localparam fetch_state_t RUN   = 2'd1;
  localparam fetch_state_t FLUSH = 2'd2;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
    logic        filled;
  } fetch_slot_t;

  function automatic logic [31:0] next_pc(input logic [31:0] pc);
    return pc + 32'd4;
  endfunction

endpackage

// File: rtl/proc_fetch_slot_buf.sv
// In-order slot buffer for the fetch stage: slots are allocated at request time,
// filled by responses in request order, and popped from the head by stage D.
module proc_fetch_slot_buf
  import proc_fetch_pkg::*;
#(
  parameter int p_slots = 4
)(
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      flush,
  input  logic                      alloc,
  input  logic [31:0]               alloc_pc,
  input  logic                      fill,
  input  logic [31:0]               fill_inst,
  input  logic                      pop,
  output fetch_slot_t               head_slot,
  output logic                      head_valid,
  output logic [$clog2(p_slots):0]  count
);

  localparam int PW = $clog2(p_slots);
  localparam int CW = PW + 1;

  fetch_slot_t   slots [p_slots];
  logic [PW-1:0] head_ptr;
  logic [PW-1:0] tail_ptr;
  logic [PW-1:0] fill_ptr;
  logic [CW-1:0] count_q;

  // fill_ptr always trails tail_ptr, so a fill never lands on the slot being allocated
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      head_ptr <= '0;
      tail_ptr <= '0;
      fill_ptr <= '0;
      count_q  <= '0;
      for (int i = 0; i < p_slots; i++) begin
        slots[i] <= '0;
      end
    end else begin
      if (alloc) begin
        slots[tail_ptr] <= '{pc: alloc_pc, inst: 32'h0, filled: 1'b0};
        tail_ptr        <= tail_ptr + PW'(1);
      end
      if (fill) begin
        slots[fill_ptr].inst   <= fill_inst;
        slots[fill_ptr].filled <= 1'b1;
        fill_ptr               <= fill_ptr + PW'(1);
      end
      if (pop) begin
        head_ptr <= head_ptr + PW'(1);
      end
      count_q <= count_q + CW'(alloc) - CW'(pop);
    end
  end

  assign head_slot  = slots[head_ptr];
  assign head_valid = (count_q != '0) && slots[head_ptr].filled;
  assign count      = count_q;

endmodule

// File: rtl/proc_fetch_unit.sv
// TinyRV1 stage-F front end: PC, imem request/response tracking, redirect flush.
// Define PROC_FETCH_PERF_EN to build the fetch/drop performance counters.
module proc_fetch_unit
  import proc_fetch_pkg::*;
#(
  parameter logic [31:0] p_reset_addr = RESET_ADDR,
  parameter int          p_slots      = 4
)(
  input  logic        clk,
  input  logic        rst,
  input  logic        redirect_val,
  input  logic [31:0] redirect_target,
  output logic        imemreq_val,
  input  logic        imemreq_rdy,
  output logic [31:0] imemreq_addr,
  input  logic        imemresp_val,
  input  logic [31:0] imemresp_data,
  output logic        inst_val_D,
  input  logic        inst_rdy_D,
  output logic [31:0] inst_D,
  output logic [31:0] pc_D,
  output logic [31:0] perf_fetch_cnt,
  output logic [31:0] perf_drop_cnt
);

  localparam int CW = $clog2(p_slots) + 1;
  // stale responses from several back-to-back redirects can exceed one buffer's worth
  localparam int DW = CW + 2;

  fetch_state_t  state;
  fetch_state_t  state_next;
  logic [31:0]   pc;
  logic [DW-1:0] inflight;
  logic [DW-1:0] drop_cnt;
  logic [DW-1:0] outstanding;
  logic [DW-1:0] inflight_next;
  logic [DW-1:0] drop_next;

  logic          issue_ok;
  logic          issue_fire;
  logic          resp_fill;
  logic          resp_drop;
  logic          pop;
  logic          head_valid;
  fetch_slot_t   head_slot;
  logic [CW-1:0] count;

  always_comb begin
    issue_ok   = (state != BOOT) && (count < CW'(p_slots)) && !redirect_val;
    issue_fire = issue_ok && imemreq_rdy;
    resp_fill  = imemresp_val && (drop_cnt == '0) && !redirect_val;
    resp_drop  = imemresp_val && (drop_cnt != '0) && !redirect_val;
    inst_val_D = head_valid && !redirect_val;
    pop        = inst_val_D && inst_rdy_D;
  end

  // A redirect turns every outstanding response (older stale ones included) into
  // a drop, except one arriving this very cycle, which the flush swallows.
  always_comb begin
    outstanding   = drop_cnt + inflight;
    drop_next     = drop_cnt;
    inflight_next = inflight;
    if (redirect_val) begin
      drop_next     = outstanding - DW'(imemresp_val);
      inflight_next = '0;
    end else begin
      if (resp_drop) begin
        drop_next = drop_cnt - DW'(1);
      end
      inflight_next = inflight + DW'(issue_fire) - DW'(resp_fill);
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      BOOT:       state_next = RUN;
      RUN, FLUSH: state_next = (drop_next != '0) ? FLUSH : RUN;
      default:    state_next = BOOT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= BOOT;
      pc       <= p_reset_addr;
      inflight <= '0;
      drop_cnt <= '0;
    end else begin
      state    <= state_next;
      inflight <= inflight_next;
      drop_cnt <= drop_next;
      if (redirect_val) begin
        pc <= redirect_target;
      end else if (issue_fire) begin
        pc <= next_pc(pc);
      end
    end
  end

  proc_fetch_slot_buf #(
    .p_slots (p_slots)
  ) u_slot_buf (
    .clk        (clk),
    .rst        (rst),
    .flush      (redirect_val),
    .alloc      (issue_fire),
    .alloc_pc   (pc),
    .fill       (resp_fill),
    .fill_inst  (imemresp_data),
    .pop        (pop),
    .head_slot  (head_slot),
    .head_valid (head_valid),
    .count      (count)
  );

  assign imemreq_val  = issue_ok;
  assign imemreq_addr = issue_ok   ? pc             : 32'h0;
  assign inst_D       = inst_val_D ? head_slot.inst : 32'h0;
  assign pc_D         = inst_val_D ? head_slot.pc   : 32'h0;

`ifdef PROC_FETCH_PERF_EN
  logic [31:0] fetch_cnt_q;
  logic [31:0] drop_cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_cnt_q <= '0;
      drop_cnt_q  <= '0;
    end else begin
      if (pop) begin
        fetch_cnt_q <= fetch_cnt_q + 32'd1;
      end
      if (resp_drop) begin
        drop_cnt_q <= drop_cnt_q + 32'd1;
      end
    end
  end

  assign perf_fetch_cnt = fetch_cnt_q;
  assign perf_drop_cnt  = drop_cnt_q;
`else
  assign perf_fetch_cnt = 32'h0;
  assign perf_drop_cnt  = 32'h0;
`endif

endmodule

// File: tb/tb_proc_fetch_unit.sv
// Self-checking bench for proc_fetch_unit: behavioural memory plus an epoch/queue
// reference model of the fetch stream, directed scenarios then randomized traffic.
module tb_proc_fetch_unit;

  localparam int          P_SLOTS  = 4;
  localparam logic [31:0] RST_ADDR = 32'h0000_0200;

  logic        clk;
  logic        rst;
  logic        redirect_val;
  logic [31:0] redirect_target;
  logic        imemreq_val;
  logic        imemreq_rdy;
  logic [31:0] imemreq_addr;
  logic        imemresp_val;
  logic [31:0] imemresp_data;
  logic        inst_val_D;
  logic        inst_rdy_D;
  logic [31:0] inst_D;
  logic [31:0] pc_D;
  logic [31:0] perf_fetch_cnt;
  logic [31:0] perf_drop_cnt;

  proc_fetch_unit #(
    .p_reset_addr (RST_ADDR),
    .p_slots      (P_SLOTS)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .redirect_val    (redirect_val),
    .redirect_target (redirect_target),
    .imemreq_val     (imemreq_val),
    .imemreq_rdy     (imemreq_rdy),
    .imemreq_addr    (imemreq_addr),
    .imemresp_val    (imemresp_val),
    .imemresp_data   (imemresp_data),
    .inst_val_D      (inst_val_D),
    .inst_rdy_D      (inst_rdy_D),
    .inst_D          (inst_D),
    .pc_D            (pc_D),
    .perf_fetch_cnt  (perf_fetch_cnt),
    .perf_drop_cnt   (perf_drop_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    int          epoch;
    longint      due;
  } mem_req_t;

  mem_req_t    mem_q[$];
  logic [31:0] fill_q[$];

  int          vec_cnt;
  int          err_cnt;
  longint      gcyc;
  longint      last_due;
  int          cyc_since_rst;
  int          epoch;
  int          occ;
  int          accept_cnt;
  int          first_req_cyc;
  int          first_del_cyc;
  logic [31:0] req_pc;
  logic [31:0] exp_fetch;
  logic [31:0] exp_drop;
  logic [31:0] data_key;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    vec_cnt++;
    if (actual !== expected) begin
      err_cnt++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d after reset)",
               tag, actual, expected, cyc_since_rst);
    end
  endtask

  function automatic logic [31:0] memData(input logic [31:0] a);
    return a ^ data_key;
  endfunction

  function automatic logic [31:0] perfExp(input logic [31:0] cnt);
`ifdef PROC_FETCH_PERF_EN
    return cnt;
`else
    return 32'h0 & cnt;
`endif
  endfunction

  // Entered and left at a negedge; rst is sampled at the one posedge in between.
  task automatic resetDut();
    rst             = 1'b1;
    redirect_val    = 1'b0;
    redirect_target = 32'h0;
    imemreq_rdy     = 1'b0;
    imemresp_val    = 1'b0;
    imemresp_data   = 32'h0;
    inst_rdy_D      = 1'b0;
    @(posedge clk);
    gcyc++;
    mem_q.delete();
    fill_q.delete();
    req_pc        = RST_ADDR;
    epoch++;
    occ           = 0;
    exp_fetch     = 32'h0;
    exp_drop      = 32'h0;
    last_due      = 0;
    cyc_since_rst = 0;
    first_req_cyc = -1;
    first_del_cyc = -1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  // rdy_mode: 0 = always ready, 1 = toggle every cycle, 2 = random ~70%
  task automatic applyStimulus(input int ncycles, input int rdy_mode, input int inst_rdy_pct,
                               input int redir_pct, input int lat_min, input int lat_max,
                               input int redir_at, input logic [31:0] redir_tgt, input int rst_at);
    bit          redir;
    bit          rdy;
    bit          drdy;
    bit          resp_now;
    bit          exp_req;
    bit          exp_iv;
    logic [31:0] tgt;
    mem_req_t    ent;
    mem_req_t    nreq;
    longint      due;
    accept_cnt = 0;
    for (int i = 0; i < ncycles; i++) begin
      if (i == rst_at) begin
        resetDut();
        continue;
      end
      redir = (i == redir_at) || ($urandom_range(99) < redir_pct);
      if (i == redir_at) tgt = redir_tgt;
      else if ($urandom_range(3) == 0) tgt = 32'hFFFF_FFF0;
      else tgt = $urandom & 32'hFFFF_FFFC;
      case (rdy_mode)
        0:       rdy = 1'b1;
        1:       rdy = ((gcyc % 2) == 1);
        default: rdy = ($urandom_range(99) < 70);
      endcase
      drdy     = ($urandom_range(99) < inst_rdy_pct);
      resp_now = (mem_q.size() > 0) && (mem_q[0].due <= gcyc);
      if (resp_now) ent = mem_q.pop_front();

      redirect_val    = redir;
      redirect_target = tgt;
      imemreq_rdy     = rdy;
      inst_rdy_D      = drdy;
      imemresp_val    = resp_now;
      imemresp_data   = resp_now ? memData(ent.addr) : 32'h0;
      #1;

      exp_req = (cyc_since_rst >= 1) && !redir && (occ < P_SLOTS);
      exp_iv  = !redir && (fill_q.size() > 0);
      checkOutput("imemreq_val", 32'(imemreq_val), 32'(exp_req));
      if (exp_req) checkOutput("imemreq_addr", imemreq_addr, req_pc);
      checkOutput("inst_val_D", 32'(inst_val_D), 32'(exp_iv));
      if (exp_iv) begin
        checkOutput("pc_D", pc_D, fill_q[0]);
        checkOutput("inst_D", inst_D, memData(fill_q[0]));
      end
      if (cyc_since_rst == 0) begin
        checkOutput("boot_imemreq_addr", imemreq_addr, 32'h0);
        checkOutput("boot_inst_D", inst_D, 32'h0);
        checkOutput("boot_pc_D", pc_D, 32'h0);
      end
      checkOutput("perf_fetch_cnt", perf_fetch_cnt, perfExp(exp_fetch));
      checkOutput("perf_drop_cnt", perf_drop_cnt, perfExp(exp_drop));

      if (exp_req && first_req_cyc < 0) first_req_cyc = cyc_since_rst;
      if (exp_iv && first_del_cyc < 0) first_del_cyc = cyc_since_rst;

      if (redir) begin
        epoch++;
        fill_q.delete();
        occ    = 0;
        req_pc = tgt;
      end else begin
        if (exp_iv && drdy) begin
          void'(fill_q.pop_front());
          occ--;
          exp_fetch++;
        end
        if (resp_now) begin
          if (ent.epoch == epoch) fill_q.push_back(ent.addr);
          else exp_drop++;
        end
        if (exp_req && rdy) begin
          due = gcyc + longint'($urandom_range(lat_max, lat_min));
          if (due < last_due) due = last_due;
          last_due   = due;
          nreq.addr  = req_pc;
          nreq.epoch = epoch;
          nreq.due   = due;
          mem_q.push_back(nreq);
          occ++;
          accept_cnt++;
          req_pc = req_pc + 32'd4;
        end
      end

      @(posedge clk);
      gcyc++;
      cyc_since_rst++;
      @(negedge clk);
    end
  endtask

  initial begin
    vec_cnt  = 0;
    err_cnt  = 0;
    gcyc     = 0;
    epoch    = 0;
    data_key = 32'h0;
    @(negedge clk);
    resetDut();

    // memory echoes the address as data, single-cycle latency
    applyStimulus(12, 0, 100, 0, 1, 1, -1, 32'h0, -1);
    checkOutput("first_req_cycle", 32'(first_req_cyc), 32'd1);
    checkOutput("first_inst_cycle", 32'(first_del_cyc), 32'd3);

    data_key = 32'hC0DE_0000;
    resetDut();
    applyStimulus(12, 0, 0, 0, 1, 1, -1, 32'h0, -1);
    checkOutput("held_req_count", 32'(accept_cnt), 32'd4);
    applyStimulus(12, 0, 100, 0, 1, 1, -1, 32'h0, -1);

    resetDut();
    applyStimulus(20, 0, 100, 0, 3, 3, 3, 32'h0000_0400, -1);
    checkOutput("redirect_two_drops", perf_drop_cnt, perfExp(32'd2));

    resetDut();
    applyStimulus(15, 0, 100, 0, 1, 1, 2, 32'h0000_0400, -1);
    checkOutput("redirect_with_resp_drops", perf_drop_cnt, 32'h0);

    resetDut();
    applyStimulus(40, 1, 100, 0, 1, 2, -1, 32'h0, -1);

    resetDut();
    applyStimulus(20, 0, 100, 0, 3, 3, 3, 32'h0000_0400, 5);

    for (int seg = 0; seg < 8; seg++) begin
      resetDut();
      applyStimulus(400, int'($urandom_range(2)), int'($urandom_range(100, 30)), 4,
                    1, int'($urandom_range(4, 1)), -1, 32'h0, int'($urandom_range(600, 50)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
